sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 90 +++++++++
 tb/tb_sram_controller.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store bridge onto a 16-bit SRAM, one word = low then high half-access.
// Optional macro SRAM_ADDR_CHECK_EN: out-of-range requests skip the SRAM and pulse addr_err in DONE.
module sram_controller #(
   parameter int unsigned WAIT_CYCLES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   output logic [31:0] read_data,
   output logic        ready,
   output logic [17:0] sram_addr,
   output logic [15:0] sram_dq_out,
   output logic        sram_dq_oe,
   input  logic [15:0] sram_dq_in,
   output logic        sram_we_n,
   output logic        addr_err
);
   typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;
   localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);
   state_t      state;
   logic [3:0]  cnt;
   logic [16:0] word_q;
   logic [31:0] data_q;
   logic        wr_q;
   logic [31:0] offset;
   logic        req;
   logic        last;
   logic        bad;
   logic        wr_act;
   logic        unused_offset;
   assign offset = address - 32'd1024;
   assign req = wr_en | rd_en;
   assign last = cnt == WAIT_LAST;
`ifdef SRAM_ADDR_CHECK_EN
   logic err_q;
   assign bad = address < 32'd1024 || offset[31:19] != '0;
   assign addr_err = state == DONE && err_q;
   assign unused_offset = ^offset[1:0];
`else
   assign bad = 1'b0;
   assign addr_err = 1'b0;
   assign unused_offset = ^{offset[31:19], offset[1:0]};
`endif
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         cnt <= '0;
         word_q <= '0;
         data_q <= '0;
         wr_q <= 1'b0;
         read_data <= '0;
`ifdef SRAM_ADDR_CHECK_EN
         err_q <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: if (req) begin
               word_q <= offset[18:2];
               data_q <= write_data;
               wr_q <= wr_en;
               cnt <= 4'd1;
               state <= bad ? DONE : LOW;
`ifdef SRAM_ADDR_CHECK_EN
               err_q <= bad;
`endif
            end
            LOW: if (last) begin
               if (!wr_q) read_data[15:0] <= sram_dq_in;
               cnt <= 4'd1;
               state <= HIGH;
            end else cnt <= cnt + 4'd1;
            HIGH: if (last) begin
               if (!wr_q) read_data[31:16] <= sram_dq_in;
               cnt <= 4'd1;
               state <= DONE;
            end else cnt <= cnt + 4'd1;
            DONE: state <= IDLE;
         endcase
      end
   end
   assign wr_act = wr_q && (state == LOW || state == HIGH);
   assign sram_we_n = !wr_act;
   assign sram_dq_oe = wr_act;
   assign sram_dq_out = !wr_act ? 16'h0 : state == HIGH ? data_q[31:16] : data_q[15:0];
   assign sram_addr = state == LOW ? {word_q, 1'b0} : state == HIGH ? {word_q, 1'b1} : 18'h0;
   assign ready = state == DONE || (state == IDLE && !req);
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: directed request table plus hand sequences for reset abort and back-to-back loads.
module tb_sram_controller;
   typedef struct {
      logic        wr;
      logic        rd;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [17:0] a0;
      logic [31:0] exp_rdata;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        wr_en = 1'b0;
   logic        rd_en = 1'b0;
   logic [31:0] address = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic        sram_dq_oe;
   logic [15:0] sram_dq_in;
   logic        sram_we_n;
   logic        addr_err;
   logic [15:0] mem [0:255];
   logic [255:0] wrt = '0;
   int          strobes = 0;
   int          checks = 0;
   int          errors = 0;
   vec_t        vecs [8];

   sram_controller #(.WAIT_CYCLES(2)) dut (
      .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .address(address),
      .write_data(write_data), .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe), .sram_dq_in(sram_dq_in),
      .sram_we_n(sram_we_n), .addr_err(addr_err)
   );

   always #5 clk = ~clk;

   // untouched SRAM words read back as A0xx so loads of fresh locations are predictable
   assign sram_dq_in = wrt[sram_addr[7:0]] ? mem[sram_addr[7:0]] : {8'hA0, sram_addr[7:0]};
   always @(posedge clk) begin
      if (!sram_we_n) begin
         mem[sram_addr[7:0]] <= sram_dq_out;
         wrt[sram_addr[7:0]] <= 1'b1;
         strobes <= strobes + 1;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input vec_t v);
      int lat;
      @(posedge clk); #1;
      wr_en = v.wr; rd_en = v.rd; address = v.addr; write_data = v.wdata;
      #1 check("ready_c0", 32'(ready), 32'd0);
      @(posedge clk); #1;
      wr_en = 1'b0; rd_en = 1'b0; address = 32'h0; write_data = 32'h5555AAAA;
      lat = 1;
      while (!ready && lat < 20) begin
         check("sram_addr", 32'(sram_addr), 32'(lat <= 2 ? v.a0 : v.a0 | 18'd1));
         check("sram_we_n", 32'(sram_we_n), 32'(!v.wr));
         check("sram_dq_oe", 32'(sram_dq_oe), 32'(v.wr));
         if (v.wr) check("sram_dq_out", 32'(sram_dq_out), 32'(lat <= 2 ? v.wdata[15:0] : v.wdata[31:16]));
         @(posedge clk); #1;
         lat++;
      end
      check("latency", 32'(lat), 32'd5);
      check("read_data", read_data, v.exp_rdata);
      check("addr_err", 32'(addr_err), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int s;
      logic [31:0] prev;
      logic [11:0] rdy_seq;
      vecs[0] = '{1'b1, 1'b0, 32'd1028,     32'hDEADBEEF, 18'd2,       32'h00000000};
      vecs[1] = '{1'b0, 1'b1, 32'd1028,     32'h0,        18'd2,       32'hDEADBEEF};
      vecs[2] = '{1'b1, 1'b1, 32'd1024,     32'h12345678, 18'd0,       32'hDEADBEEF};
      vecs[3] = '{1'b0, 1'b1, 32'd1024,     32'h0,        18'd0,       32'h12345678};
      vecs[4] = '{1'b0, 1'b1, 32'd1040,     32'h0,        18'd8,       32'hA009A008};
      vecs[5] = '{1'b1, 1'b0, 32'h000803FC, 32'hCAFEF00D, 18'h3FFFE,   32'hA009A008};
      vecs[6] = '{1'b0, 1'b1, 32'h000803FC, 32'h0,        18'h3FFFE,   32'hCAFEF00D};
      vecs[7] = '{1'b0, 1'b1, 32'd1031,     32'h0,        18'd2,       32'hDEADBEEF};
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("rst_ready", 32'(ready), 32'd1);
      check("rst_we_n", 32'(sram_we_n), 32'd1);
      check("rst_oe", 32'(sram_dq_oe), 32'd0);
      check("rst_addr", 32'(sram_addr), 32'd0);
      check("rst_dq", 32'(sram_dq_out), 32'd0);
      check("rst_rdata", read_data, 32'd0);
      check("rst_err", 32'(addr_err), 32'd0);
      for (int i = 0; i < 8; i++) run_vec(vecs[i]);
      // reset asserted during the high half of a store
      @(posedge clk); #1;
      wr_en = 1'b1; address = 32'd1100; write_data = 32'h01020304;
      @(posedge clk); #1;
      wr_en = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check("mid_we_n", 32'(sram_we_n), 32'd0);
      check("mid_addr", 32'(sram_addr), 32'd39);
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
      #1;
      check("abort_we_n", 32'(sram_we_n), 32'd1);
      check("abort_ready", 32'(ready), 32'd1);
      check("abort_addr", 32'(sram_addr), 32'd0);
      check("abort_rdata", read_data, 32'd0);
      s = strobes;
      repeat (6) @(posedge clk);
      #1 check("abort_strobes", 32'(strobes), 32'(s));
      // back-to-back loads with rd_en held; address change mid-access must be ignored
      @(posedge clk); #1;
      rd_en = 1'b1; address = 32'd1028;
      for (int c = 0; c < 12; c++) begin
         if (c > 0) begin
            @(posedge clk); #1;
         end
         if (c == 2) address = 32'd1024;
         #1 rdy_seq[c] = ready;
         if (c == 6) check("b2b_first", read_data, 32'hDEADBEEF);
      end
      rd_en = 1'b0;
      check("b2b_ready", 32'(rdy_seq), 32'(12'b1000_0010_0000));
      check("b2b_second", read_data, 32'h12345678);
`ifdef SRAM_ADDR_CHECK_EN
      s = strobes;
      prev = read_data;
      @(posedge clk); #1;
      rd_en = 1'b1; address = 32'd512;
      #1;
      check("err_ready_c0", 32'(ready), 32'd0);
      check("err_flag_c0", 32'(addr_err), 32'd0);
      @(posedge clk); #1;
      rd_en = 1'b0;
      check("err_ready", 32'(ready), 32'd1);
      check("err_flag", 32'(addr_err), 32'd1);
      check("err_addr", 32'(sram_addr), 32'd0);
      @(posedge clk); #1;
      check("err_clear", 32'(addr_err), 32'd0);
      check("err_strobes", 32'(strobes), 32'(s));
      check("err_rdata", read_data, prev);
`else
      prev = 32'h12345678;
      run_vec('{1'b0, 1'b1, 32'd512, 32'h0, 18'h3FF00, prev});
      check("trunc_err", 32'(addr_err), 32'd0);
`endif
      @(posedge clk); #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
